// File: rtl/subservient_uart_dbg_pkg.sv
// Shared command codes, response code and FSM state types for the UART debug bridge.
package subservient_uart_dbg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] RSP_OK    = 8'h2B;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } cmd_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/subservient_uart_byte_rx.sv
// 8N1 byte receiver: synchronizes the serial line, times each bit from the
// start edge and flags frames whose stop bit reads low.
module subservient_uart_byte_rx
    import subservient_uart_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state, state_n;
    logic [1:0]       sync;
    logic             rx_prev;
    logic             rx_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             valid_n;
    logic             err_n;

    assign rx_s    = sync[1];
    assign rx_data = shreg;

    // Two-flop synchronizer plus a delayed copy used to spot the start edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], i_uart_rx};
            rx_prev <= rx_s;
        end
    end

    // Frame state, bit timer and shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
        end
    end

    // Start is re-checked at half a bit, then every bit is sampled at its centre
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_END) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/subservient_uart_dbg.sv
// UART-to-Wishbone debug bridge: parses host commands, performs single 32-bit
// bus accesses, toggles debug mode and serializes replies back to the host.
module subservient_uart_dbg
    import subservient_uart_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_rx_err
);

    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_frame_err;

    cmd_state_t       state, state_n;
    logic [31:0]      adr_n, dat_n;
    logic             we_n, debug_n;
    logic [1:0]       byte_cnt, byte_cnt_n;
    logic [31:0]      rsp_word, rsp_word_n;
    logic [1:0]       rsp_left, rsp_left_n;

    logic             tx_load;
    logic [7:0]       tx_byte;
    logic             tx_busy;
    logic             tx_done;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bits;
    logic [8:0]       tx_shift;

    subservient_uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_uart_rx   (i_uart_rx),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_frame_err(rx_frame_err)
    );

    assign o_wb_dbg_sel = 4'hF;
    assign o_wb_dbg_stb = (state == BUS);
    assign tx_done      = tx_busy && (tx_cnt == BIT_END) && (tx_bits == 4'd0);

    // Framing errors latch until the next reset
    always_ff @(posedge i_clk) begin
        if (i_rst)             o_rx_err <= 1'b0;
        else if (rx_frame_err) o_rx_err <= 1'b1;
    end

    // Command FSM state and the registers it loads
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_wb_dbg_adr <= '0;
            o_wb_dbg_dat <= '0;
            o_wb_dbg_we  <= 1'b0;
            o_debug_mode <= 1'b1;
            byte_cnt     <= '0;
            rsp_word     <= '0;
            rsp_left     <= '0;
        end else begin
            state        <= state_n;
            o_wb_dbg_adr <= adr_n;
            o_wb_dbg_dat <= dat_n;
            o_wb_dbg_we  <= we_n;
            o_debug_mode <= debug_n;
            byte_cnt     <= byte_cnt_n;
            rsp_word     <= rsp_word_n;
            rsp_left     <= rsp_left_n;
        end
    end

    // Decode commands, collect operands, run the bus cycle and feed reply bytes
    always_comb begin
        state_n    = state;
        adr_n      = o_wb_dbg_adr;
        dat_n      = o_wb_dbg_dat;
        we_n       = o_wb_dbg_we;
        debug_n    = o_debug_mode;
        byte_cnt_n = byte_cnt;
        rsp_word_n = rsp_word;
        rsp_left_n = rsp_left;
        tx_load    = 1'b0;
        tx_byte    = RSP_OK;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE: begin we_n = 1'b1; state_n = ADDR; end
                        CMD_READ:  begin we_n = 1'b0; state_n = ADDR; end
                        CMD_GO:    begin debug_n = 1'b0; tx_load = 1'b1; rsp_left_n = '0; state_n = RESP; end
                        CMD_HALT:  begin debug_n = 1'b1; tx_load = 1'b1; rsp_left_n = '0; state_n = RESP; end
                        default: ;
                    endcase
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    adr_n      = {rx_data, o_wb_dbg_adr[31:8]};
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) state_n = o_wb_dbg_we ? DATA : BUS;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    dat_n      = {rx_data, o_wb_dbg_dat[31:8]};
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) state_n = BUS;
                end
            end
            BUS: begin
                if (i_wb_dbg_ack) begin
                    tx_load    = 1'b1;
                    rsp_left_n = '0;
                    state_n    = RESP;
                    if (!o_wb_dbg_we) begin
                        tx_byte    = i_wb_dbg_rdt[7:0];
                        rsp_word_n = {8'h00, i_wb_dbg_rdt[31:8]};
                        rsp_left_n = 2'd3;
                    end
                end
            end
            RESP: begin
                if (tx_done) begin
                    if (rsp_left != 2'd0) begin
                        tx_load    = 1'b1;
                        tx_byte    = rsp_word[7:0];
                        rsp_word_n = {8'h00, rsp_word[31:8]};
                        rsp_left_n = rsp_left - 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // TX serializer; a new byte may load on the last stop-bit cycle for gapless replies
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_uart_tx <= 1'b1;
            tx_busy   <= 1'b0;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            tx_shift  <= '1;
        end else if (tx_load) begin
            o_uart_tx <= 1'b0;
            tx_shift  <= {1'b1, tx_byte};
            tx_bits   <= 4'd9;
            tx_cnt    <= '0;
            tx_busy   <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_END) begin
                tx_cnt <= '0;
                if (tx_bits == 4'd0) begin
                    tx_busy <= 1'b0;
                end else begin
                    o_uart_tx <= tx_shift[0];
                    tx_shift  <= {1'b1, tx_shift[8:1]};
                    tx_bits   <= tx_bits - 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule
